// File: rtl/shift_pipe.sv
// shift_pipe: pipelined ARM operand-2 barrel shifter (LSL/LSR/ASR/ROR/RRX)
// with valid/ready handshakes and a sideband tag.
// Optional build macro SHIFT_PIPE_IMM_EN adds in_imm (ARM immediate-shift
// encoding, where a zero amount selects the special forms).
//
// Stage 0 decodes the operation into {preloaded data, carry, shift kind,
// shift amount}. Every stage then applies its share of the log2(WIDTH)
// shift levels. The carry is final after decode, and the levels compose
// for every kind, so later stages only move data.

module shift_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int LW    = 5,
  parameter int LO    = 0,
  parameter int NLV   = 1
) (
  input  logic [WIDTH-1:0] d_in,
  input  logic [1:0]       kind,
  input  logic [LW-1:0]    sa,
  output logic [WIDTH-1:0] d_out
);
  localparam logic [1:0] K_LSL = 2'd0, K_LSR = 2'd1, K_ASR = 2'd2, K_ROR = 2'd3;

  // Only the levels owned by this stage read sa. The other bits are folded here.
  logic unused_sa;
  assign unused_sa = ^sa;

  // Levels LO..LO+NLV-1. Each level shifts by 2^level when its amount bit is set.
  always_comb begin
    d_out = d_in;
    for (int i = 0; i < NLV; i++) begin
      if (sa[LO+i]) begin
        case (kind)
          K_LSL:   d_out = d_out << (1 << (LO+i));
          K_LSR:   d_out = d_out >> (1 << (LO+i));
          K_ASR:   d_out = $signed(d_out) >>> (1 << (LO+i));
          K_ROR:   d_out = (d_out >> (1 << (LO+i))) | (d_out << (WIDTH - (1 << (LO+i))));
          default: d_out = d_out;
        endcase
      end
    end
  end
endmodule

module shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [2:0]        in_op,
  input  logic [7:0]        in_amt,
  input  logic              in_cin,
  input  logic [TAG_W-1:0]  in_tag,
`ifdef SHIFT_PIPE_IMM_EN
  input  logic              in_imm,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_carry,
  output logic [TAG_W-1:0]  out_tag
);
  localparam int LW = $clog2(WIDTH);
  localparam int NB = LW / STAGES;
  localparam int NR = LW % STAGES;
  localparam logic [7:0] WN = 8'(WIDTH);
  localparam logic [2:0] OP_LSL = 3'd0, OP_LSR = 3'd1, OP_ASR = 3'd2, OP_ROR = 3'd3, OP_RRX = 3'd4;
  localparam logic [1:0] K_LSL = 2'd0, K_LSR = 2'd1, K_ASR = 2'd2, K_ROR = 2'd3;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       kind;
    logic [LW-1:0]    sa;
    logic             carry;
    logic [TAG_W-1:0] tag;
  } slot_t;

  slot_t                dec;
  slot_t [STAGES-1:0]   slot_q, slot_d;
  logic  [STAGES-1:0]   vld_pipe, adv, vin;
  logic  [2:0]          op;
  logic  [7:0]          n;
  logic  [LW-1:0]       nlo, nm1, nneg;

  // Effective op/amount. Immediate encoding remaps amount 0 to the special forms.
  always_comb begin
    op = in_op;
    n  = in_amt;
`ifdef SHIFT_PIPE_IMM_EN
    if (in_imm) begin
      n = {3'b000, in_amt[4:0]};
      if (n == 8'd0) begin
        case (in_op)
          OP_LSR, OP_ASR: n  = WN;
          OP_ROR:         op = OP_RRX;
          default:        n  = 8'd0;
        endcase
      end
    end
`endif
    nlo  = n[LW-1:0];
    nm1  = nlo - LW'(1);
    nneg = ~nlo + LW'(1);
  end

  // Decode: out-of-range and special cases are resolved here by preloading the data.
  // The carry is final after this point.
  always_comb begin
    dec = '{data: in_a, kind: K_ROR, sa: '0, carry: in_cin, tag: in_tag};
    if (op == OP_RRX) begin
      dec.data  = {in_cin, in_a[WIDTH-1:1]};
      dec.carry = in_a[0];
    end else if (op <= OP_ROR && n != 8'd0) begin
      case (op)
        OP_LSL:
          if (n < WN) begin
            dec.kind = K_LSL; dec.sa = nlo; dec.carry = in_a[nneg];
          end else begin
            dec.data = '0; dec.carry = (n == WN) ? in_a[0] : 1'b0;
          end
        OP_LSR:
          if (n < WN) begin
            dec.kind = K_LSR; dec.sa = nlo; dec.carry = in_a[nm1];
          end else begin
            dec.data = '0; dec.carry = (n == WN) ? in_a[WIDTH-1] : 1'b0;
          end
        OP_ASR:
          if (n < WN) begin
            dec.kind = K_ASR; dec.sa = nlo; dec.carry = in_a[nm1];
          end else begin
            dec.data = {WIDTH{in_a[WIDTH-1]}}; dec.carry = in_a[WIDTH-1];
          end
        default: begin
          // A rotate that is a multiple of WIDTH leaves the data unchanged, and the carry is the MSB.
          dec.kind  = K_ROR;
          dec.sa    = nlo;
          dec.carry = (nlo == '0) ? in_a[WIDTH-1] : in_a[nm1];
        end
      endcase
    end
  end

  // Per-stage shift slice. The remainder levels go to the earliest stages.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int NLV = NB + ((k < NR) ? 1 : 0);
    localparam int LO  = k * NB + ((k < NR) ? k : NR);
    slot_t                src;
    logic  [WIDTH-1:0]    shd;
    if (k == 0) begin : g_src0
      assign src = dec;
    end else begin : g_srcn
      assign src = slot_q[k-1];
    end
    shift_pipe_stage #(.WIDTH(WIDTH), .LW(LW), .LO(LO), .NLV(NLV)) u_stg (
      .d_in (src.data),
      .kind (src.kind),
      .sa   (src.sa),
      .d_out(shd)
    );
    assign slot_d[k] = {shd, src.kind, src.sa, src.carry, src.tag};
  end

  // Backpressure: a slot moves when it is empty or the slot after it moves.
  always_comb begin
    adv = '0;
    vin = '0;
    adv[STAGES-1] = ~vld_pipe[STAGES-1] | out_ready;
    for (int k = STAGES-2; k >= 0; k--) adv[k] = ~vld_pipe[k] | adv[k+1];
    vin[0] = in_valid & in_ready;
    for (int k = 1; k < STAGES; k++) vin[k] = vld_pipe[k-1];
  end

  assign in_ready = adv[0] & ~flush;

  // Slot registers. Flush clears only the valids. A payload loads only with a valid item.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      slot_q   <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          vld_pipe[k] <= vin[k];
          if (vin[k]) slot_q[k] <= slot_d[k];
        end
      end
    end
  end

  assign out_valid = vld_pipe[STAGES-1];
  assign out_data  = slot_q[STAGES-1].data;
  assign out_carry = slot_q[STAGES-1].carry;
  assign out_tag   = slot_q[STAGES-1].tag;

  logic unused_tail;
  assign unused_tail = ^{slot_q[STAGES-1].kind, slot_q[STAGES-1].sa};
endmodule

// File: tb/tb_shift_pipe.sv
// Directed self-checking bench for shift_pipe (WIDTH=32, STAGES=2).
// With SHIFT_PIPE_IMM_EN defined, the immediate-encoding cases also run.
module tb_shift_pipe;
  logic        clk, rst_n, flush, in_valid, in_ready, in_cin, in_imm;
  logic [31:0] in_a, out_data;
  logic [2:0]  in_op;
  logic [7:0]  in_amt;
  logic [3:0]  in_tag, out_tag;
  logic        out_valid, out_ready, out_carry;
  int          checks = 0;
  int          failures = 0;

  shift_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_op(in_op),
    .in_amt(in_amt), .in_cin(in_cin), .in_tag(in_tag),
`ifdef SHIFT_PIPE_IMM_EN
    .in_imm(in_imm),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .out_tag(out_tag)
  );

`ifndef SHIFT_PIPE_IMM_EN
  logic unused_imm;
  assign unused_imm = in_imm;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  amt;
    logic [31:0] a;
    logic        cin;
    logic        imm;
    logic [31:0] ed;
    logic        ec;
  } vec_t;

  // Sends one op into an idle pipe and returns the result. Data is X on timeout.
  task automatic do_op(input logic [2:0] op, input logic [7:0] amt, input logic [31:0] a,
                       input logic cin, input logic imm, output logic [31:0] d, output logic c);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_amt = amt; in_a = a; in_cin = cin; in_imm = imm;
    in_tag = 4'hA; out_ready = 1'b1; flush = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    d = 'x; c = 1'bx;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) begin d = out_data; c = out_carry; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_carry !== 1'b0 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset got v=%b d=%h c=%b t=%h rdy=%b want 0 0 0 0 1",
               out_valid, out_data, out_carry, out_tag, in_ready);
    end
  endtask

  task automatic test_lsl_lsr();
    vec_t v [7];
    logic [31:0] d; logic c;
    v[0] = '{3'd1, 8'd1,   32'h80000001, 1'b0, 1'b0, 32'h40000000, 1'b1};
    v[1] = '{3'd1, 8'd32,  32'h80000001, 1'b0, 1'b0, 32'h00000000, 1'b1};
    v[2] = '{3'd1, 8'd33,  32'h80000001, 1'b0, 1'b0, 32'h00000000, 1'b0};
    v[3] = '{3'd0, 8'd31,  32'h00000003, 1'b0, 1'b0, 32'h80000000, 1'b1};
    v[4] = '{3'd0, 8'd32,  32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1};
    v[5] = '{3'd1, 8'd31,  32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000001, 1'b1};
    v[6] = '{3'd1, 8'd255, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000, 1'b0};
    foreach (v[i]) begin
      do_op(v[i].op, v[i].amt, v[i].a, v[i].cin, v[i].imm, d, c);
      checks++;
      if (d !== v[i].ed || c !== v[i].ec) begin
        failures++;
        $display("FAIL lsl_lsr[%0d] got d=%h c=%b want d=%h c=%b", i, d, c, v[i].ed, v[i].ec);
      end
    end
  endtask

  task automatic test_asr_zero();
    vec_t v [8];
    logic [31:0] d; logic c;
    v[0] = '{3'd2, 8'd4,  32'h80000000, 1'b0, 1'b0, 32'hF8000000, 1'b0};
    v[1] = '{3'd2, 8'd40, 32'h80000000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1};
    v[2] = '{3'd2, 8'd32, 32'h40000000, 1'b1, 1'b0, 32'h00000000, 1'b0};
    v[3] = '{3'd0, 8'd0,  32'h12345678, 1'b1, 1'b0, 32'h12345678, 1'b1};
    v[4] = '{3'd1, 8'd0,  32'h12345678, 1'b1, 1'b0, 32'h12345678, 1'b1};
    v[5] = '{3'd2, 8'd0,  32'h12345678, 1'b1, 1'b0, 32'h12345678, 1'b1};
    v[6] = '{3'd3, 8'd0,  32'h12345678, 1'b1, 1'b0, 32'h12345678, 1'b1};
    v[7] = '{3'd6, 8'd9,  32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
    foreach (v[i]) begin
      do_op(v[i].op, v[i].amt, v[i].a, v[i].cin, v[i].imm, d, c);
      checks++;
      if (d !== v[i].ed || c !== v[i].ec) begin
        failures++;
        $display("FAIL asr_zero[%0d] got d=%h c=%b want d=%h c=%b", i, d, c, v[i].ed, v[i].ec);
      end
    end
  endtask

  task automatic test_ror_rrx();
    vec_t v [7];
    logic [31:0] d; logic c;
    v[0] = '{3'd3, 8'd36,  32'h000000F1, 1'b0, 1'b0, 32'h1000000F, 1'b0};
    v[1] = '{3'd3, 8'd32,  32'h000000F1, 1'b0, 1'b0, 32'h000000F1, 1'b0};
    v[2] = '{3'd3, 8'd64,  32'h80000001, 1'b0, 1'b0, 32'h80000001, 1'b1};
    v[3] = '{3'd3, 8'd8,   32'h000000F1, 1'b0, 1'b0, 32'hF1000000, 1'b1};
    v[4] = '{3'd3, 8'd255, 32'h80000001, 1'b0, 1'b0, 32'h00000003, 1'b0};
    v[5] = '{3'd4, 8'd0,   32'h00000003, 1'b1, 1'b0, 32'h80000001, 1'b1};
    v[6] = '{3'd4, 8'd5,   32'h00000002, 1'b0, 1'b0, 32'h00000001, 1'b0};
    foreach (v[i]) begin
      do_op(v[i].op, v[i].amt, v[i].a, v[i].cin, v[i].imm, d, c);
      checks++;
      if (d !== v[i].ed || c !== v[i].ec) begin
        failures++;
        $display("FAIL ror_rrx[%0d] got d=%h c=%b want d=%h c=%b", i, d, c, v[i].ed, v[i].ec);
      end
    end
  endtask

`ifdef SHIFT_PIPE_IMM_EN
  task automatic test_imm();
    vec_t v [6];
    logic [31:0] d; logic c;
    v[0] = '{3'd1, 8'd0,   32'h80000000, 1'b0, 1'b1, 32'h00000000, 1'b1};
    v[1] = '{3'd3, 8'd0,   32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b1};
    v[2] = '{3'd2, 8'd0,   32'h80000000, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1};
    v[3] = '{3'd0, 8'd0,   32'h00000005, 1'b1, 1'b1, 32'h00000005, 1'b1};
    v[4] = '{3'd1, 8'h21,  32'h80000001, 1'b0, 1'b1, 32'h40000000, 1'b1};
    v[5] = '{3'd1, 8'd0,   32'h80000000, 1'b0, 1'b0, 32'h80000000, 1'b0};
    foreach (v[i]) begin
      do_op(v[i].op, v[i].amt, v[i].a, v[i].cin, v[i].imm, d, c);
      checks++;
      if (d !== v[i].ed || c !== v[i].ec) begin
        failures++;
        $display("FAIL imm[%0d] got d=%h c=%b want d=%h c=%b", i, d, c, v[i].ed, v[i].ec);
      end
    end
  endtask
`endif

  // Six ROR#1 ops, issued back to back, with a 3-cycle output stall at the first result.
  task automatic test_back_to_back();
    int sent = 0, got = 0, stall = 0, first = -1;
    logic        was_stalled = 1'b0;
    logic [31:0] hold_d, ag;
    logic        hold_c;
    logic [3:0]  hold_t;
    in_imm = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (was_stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold_d || out_carry !== hold_c || out_tag !== hold_t) begin
          failures++;
          $display("FAIL b2b_hold cyc=%0d got v=%b d=%h c=%b t=%h want 1 %h %b %h",
                   cyc, out_valid, out_data, out_carry, out_tag, hold_d, hold_c, hold_t);
        end
      end
      if (out_valid && first < 0) begin
        first = cyc; stall = 3;
        checks++;
        if (cyc != 2) begin
          failures++;
          $display("FAIL b2b_latency got first out_valid at cycle %0d want 2", cyc);
        end
      end
      out_ready = (stall > 0) ? 1'b0 : 1'b1;
      if (stall > 0) stall--;
      in_valid = (sent < 6);
      in_a = 32'(sent + 1); in_op = 3'd3; in_amt = 8'd1; in_cin = 1'b0; in_tag = sent[3:0];
      #1;
      if (cyc == 2) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_backpressure got in_ready=%b want 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        ag = 32'(got + 1);
        checks++;
        if (out_tag !== got[3:0] || out_data !== {ag[0], ag[31:1]} || out_carry !== ag[0]) begin
          failures++;
          $display("FAIL b2b_order got t=%h d=%h c=%b want t=%h d=%h c=%b",
                   out_tag, out_data, out_carry, got[3:0], {ag[0], ag[31:1]}, ag[0]);
        end
        got++;
      end
      was_stalled = out_valid && !out_ready;
      hold_d = out_data; hold_c = out_carry; hold_t = out_tag;
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 6) begin
      failures++;
      $display("FAIL b2b_count got %0d results want 6", got);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    @(negedge clk);
    out_ready = 1'b0; flush = 1'b0; in_valid = 1'b1; in_op = 3'd5; in_amt = 8'd0;
    in_a = 32'h0000AAAA; in_tag = 4'h1;
    @(negedge clk);
    in_tag = 4'h2;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_setup got out_valid=%b want 1", out_valid);
    end
    flush = 1'b1; in_tag = 4'h3;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready got in_ready=%b want 0", in_ready);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear got out_valid=%b want 0", out_valid);
    end
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL flush_drop got %0d results after flush want 0", seen);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd5; in_amt = 8'd0;
    in_a = 32'hCAFE0001; in_cin = 1'b1; in_tag = 4'h7;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hCAFE0001 || out_tag !== 4'h7) begin
      failures++;
      $display("FAIL areset_setup got v=%b d=%h t=%h want 1 cafe0001 7", out_valid, out_data, out_tag);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_carry !== 1'b0 || out_tag !== 4'h0) begin
      failures++;
      $display("FAIL areset_now got v=%b d=%h c=%b t=%h want all 0", out_valid, out_data, out_carry, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL areset_release got v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_op = '0; in_amt = '0;
    in_cin = 1'b0; in_tag = '0; in_imm = 1'b0; out_ready = 1'b1;
    test_reset();
    test_lsl_lsr();
    test_asr_zero();
    test_ror_rrx();
`ifdef SHIFT_PIPE_IMM_EN
    test_imm();
`endif
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the ARM datapath; next generation of the combinational operand-2 shifter.
- Implements full ARM register-shift semantics (LSL/LSR/ASR/ROR/RRX) with correct carry-out for amounts 0..255, at any power-of-two width.
- Splits the logarithmic shift network across STAGES registers behind valid/ready handshakes, so it can sit between the register-read and ALU stages with backpressure.

Parameters:
- WIDTH, 32, operand width; power of two, 8..64.
- STAGES, 2, pipeline depth and latency in cycles; 1..log2(WIDTH).
- TAG_W, 4, width of the sideband tag passed through unmodified.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  input operation valid.
- in_ready  out  1  input accept; transfer when in_valid & in_ready.
- in_a  in  WIDTH  operand.
- in_op  in  3  0=LSL 1=LSR 2=ASR 3=ROR 4=RRX; 5..7 pass-through.
- in_amt  in  8  shift amount (register-specified).
- in_cin  in  1  carry flag in.
- in_tag  in  TAG_W  sideband tag.
- in_imm  in  1  immediate-encoding select; present only with SHIFT_PIPE_IMM_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  shifted result.
- out_carry  out  1  shifter carry-out.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids 0; out_valid=0, out_data=0, out_carry=0, out_tag=0. in_ready=1 from the first edge after release. Reset mid-operation discards all in-flight items.
- Pipeline: STAGES register slots. Slot k advances when it is empty or slot k+1 (or the output) advances. in_ready = ~valid[0] | advance[0]. Ready propagates combinationally; there is no skid buffer.
- Latency: an item accepted at edge t shows out_valid in the cycle after edge t+STAGES-1, unless stalled. Throughput is 1 item/cycle when out_ready=1.
- Ordering: strictly FIFO. No drop or duplication under any out_ready pattern. out_* are held stable while out_valid & ~out_ready.
- Flush: at the edge it is sampled high, all valids clear. While flush=1, in_ready=0 and any input presented is dropped. flush has priority over advance.
- Decode in stage 0: amount is normalised and carry computed. The log2(WIDTH) shift levels are split across stages, with the remainder in the earliest stages.
- Semantics for amount n, W=WIDTH:
  - n=0 (LSL/LSR/ASR/ROR): data=a, carry=cin.
  - LSL: n<W gives a<<n, carry=a[W-n]. n=W gives 0, carry=a[0]. n>W gives 0, carry=0.
  - LSR: n<W gives a>>n, carry=a[n-1]. n=W gives 0, carry=a[W-1]. n>W gives 0, carry=0.
  - ASR: n<W gives arithmetic a>>>n, carry=a[n-1]. n>=W gives all bits = a[W-1], carry=a[W-1].
  - ROR: if n mod W = 0 (n≠0), data=a, carry=a[W-1]. Otherwise rotate right by n mod W, carry=data[W-1].
  - RRX: data={cin, a[W-1:1]}, carry=a[0]; amount ignored.
  - op 5..7: data=a, carry=cin.
- in_tag travels with its data unchanged.

Optional Feature:
- Macro SHIFT_PIPE_IMM_EN.
- Defined: adds in_imm. When in_imm=1, in_amt[4:0] is used (upper bits ignored), and amount 0 is ARM immediate encoding: LSL#0 gives a with carry=cin; LSR#0 behaves as LSR by W; ASR#0 behaves as ASR by W; ROR#0 behaves as RRX. When in_imm=0, register semantics above apply.
- Undefined: in_imm port absent; register semantics only.

Test Plan (WIDTH=32, STAGES=2):
- LSR a=0x80000001: n=1 -> 0x40000000, c=1; n=32 -> 0x00000000, c=1; n=33 -> 0x00000000, c=0. LSL a=0x00000003, n=31 -> 0x80000000, c=1.
- ASR a=0x80000000: n=4 -> 0xF8000000, c=0; n=40 -> 0xFFFFFFFF, c=1. Any op with n=0, cin=1 -> data=a, c=1.
- ROR a=0x000000F1: n=36 -> 0x1000000F, c=0; n=32 -> 0x000000F1, c=0. RRX a=0x00000003, cin=1 -> 0x80000001, c=1.
- Back-to-back 6 ops with tags 0..5; out_ready low for 3 cycles after first out_valid -> in_ready drops once 2 items are held; outputs in order with tags 0..5, none lost or duplicated, out_* stable during stall. First result appears 2 cycles after accept.
- flush with 2 items in flight and in_valid=1 -> no out_valid next cycle, in_ready=0 during flush, presented item dropped. Also: rst_n low mid-stream -> out_valid=0, out_data=0 immediately (asynchronous).
- SHIFT_PIPE_IMM_EN, in_imm=1: LSR n=0, a=0x80000000 -> 0x00000000, c=1; ROR n=0, a=0x00000001, cin=0 -> 0x00000000, c=1.
